// File: rtl/float32_pkg.sv
// rtl/float32_pkg.sv - shared constants, types and unpack helper for the float32 multiplier
package float32_pkg;
    localparam int BIAS  = 127;
    localparam int EXP_W = 8;
    localparam int MAN_W = 23;
    localparam logic [31:0] QNAN = 32'h7FC0_0000;

    localparam int FLAG_INVALID   = 2;
    localparam int FLAG_OVERFLOW  = 1;
    localparam int FLAG_UNDERFLOW = 0;

    // man carries the hidden leading one
    typedef struct packed {
        logic             sign;
        logic [EXP_W-1:0] exp;
        logic [MAN_W:0]   man;
        logic             is_zero;
        logic             is_inf;
        logic             is_nan;
        logic             is_snan;
    } unpacked_float_t;

    typedef enum logic [1:0] {SP_NONE, SP_ZERO, SP_INF, SP_NAN} special_e;

    // Subnormals (exp=0) are classified as zero: flush-to-zero on input
    function automatic unpacked_float_t unpack_f32(input logic [31:0] x);
        unpacked_float_t u;
        u.sign    = x[31];
        u.exp     = x[30:23];
        u.man     = {1'b1, x[22:0]};
        u.is_zero = (x[30:23] == '0);
        u.is_inf  = (x[30:23] == '1) && (x[22:0] == '0);
        u.is_nan  = (x[30:23] == '1) && (x[22:0] != '0);
        u.is_snan = u.is_nan && !x[22];
        return u;
    endfunction
endpackage

// File: rtl/float32_mul_pipe_if.sv
// rtl/float32_mul_pipe_if.sv - operand/result handshake bundle for float32_mul_pipe
interface float32_mul_pipe_if #(
    parameter int LANES = 4
);
    logic                  in_valid;
    logic                  out_ready;
    logic [32*LANES-1:0]   in_A;
    logic [32*LANES-1:0]   in_B;
    logic                  out_valid;
    logic                  in_result_ready;
    logic [32*LANES-1:0]   out_result;
    logic [3*LANES-1:0]    out_flags;

    modport master (
        output in_valid, in_A, in_B, in_result_ready,
        input  out_ready, out_valid, out_result, out_flags
    );

    modport slave (
        input  in_valid, in_A, in_B, in_result_ready,
        output out_ready, out_valid, out_result, out_flags
    );
endinterface

// File: rtl/float32_mul_lane.sv
// rtl/float32_mul_lane.sv - one three-stage float32 multiply lane (unpack, multiply, round/pack)
module float32_mul_lane
    import float32_pkg::*;
#(
    parameter bit FLAGS_EN = 1'b1
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        en_i,
    input  logic        v0_i,
    input  logic        v1_i,
    input  logic        v2_i,
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    output logic [31:0] result_o,
    output logic [2:0]  flags_o
);
    localparam logic signed [9:0] BIAS_S = 10'(BIAS);

    unpacked_float_t ua, ub;
    special_e        sp_d;
    logic            inf_zero, inv_d;

    assign ua       = unpack_f32(a_i);
    assign ub       = unpack_f32(b_i);
    assign inf_zero = (ua.is_inf && ub.is_zero) || (ua.is_zero && ub.is_inf);
    assign inv_d    = inf_zero || ua.is_snan || ub.is_snan;

    always_comb begin
        sp_d = SP_NONE;
        if (ua.is_nan || ub.is_nan || inf_zero) sp_d = SP_NAN;
        else if (ua.is_inf || ub.is_inf)        sp_d = SP_INF;
        else if (ua.is_zero || ub.is_zero)      sp_d = SP_ZERO;
    end

    logic            s1_sign_q, s1_inv_q;
    logic [7:0]      s1_ea_q, s1_eb_q;
    logic [23:0]     s1_ma_q, s1_mb_q;
    special_e        s1_sp_q;

    always_ff @(posedge clk_i) begin
        if (en_i && v0_i) begin
            s1_sign_q <= ua.sign ^ ub.sign;
            s1_ea_q   <= ua.exp;
            s1_eb_q   <= ub.exp;
            s1_ma_q   <= ua.man;
            s1_mb_q   <= ub.man;
            s1_sp_q   <= sp_d;
            s1_inv_q  <= inv_d;
        end
    end

    logic               s2_sign_q, s2_inv_q;
    logic [47:0]        s2_prod_q;
    logic signed [9:0]  s2_exp_q;
    special_e           s2_sp_q;

    always_ff @(posedge clk_i) begin
        if (en_i && v1_i) begin
            s2_sign_q <= s1_sign_q;
            s2_prod_q <= 48'(s1_ma_q) * 48'(s1_mb_q);
            s2_exp_q  <= $signed({2'b00, s1_ea_q}) + $signed({2'b00, s1_eb_q}) - BIAS_S;
            s2_sp_q   <= s1_sp_q;
            s2_inv_q  <= s1_inv_q;
        end
    end

    logic [23:0]       mant;
    logic              g_bit, r_bit, s_bit, rnd;
    logic [24:0]       sum;
    logic signed [9:0] e_fin;
    logic [31:0]       res_d;
    logic [2:0]        flg_d;

    // Normalise on product bit 47, then round-to-nearest-even on guard/round/sticky
    always_comb begin
        mant  = s2_prod_q[46:23];
        g_bit = s2_prod_q[22];
        r_bit = s2_prod_q[21];
        s_bit = |s2_prod_q[20:0];
        e_fin = s2_exp_q;
        if (s2_prod_q[47]) begin
            mant  = s2_prod_q[47:24];
            g_bit = s2_prod_q[23];
            r_bit = s2_prod_q[22];
            s_bit = |s2_prod_q[21:0];
            e_fin = s2_exp_q + 10'sd1;
        end
        rnd = g_bit && (r_bit || s_bit || mant[0]);
        sum = {1'b0, mant} + {24'd0, rnd};
        if (sum[24]) e_fin = e_fin + 10'sd1;

        flg_d = 3'b000;
        res_d = {s2_sign_q, e_fin[7:0], sum[22:0]};
        if (e_fin >= 10'sd255) begin
            res_d                = {s2_sign_q, 8'hFF, 23'd0};
            flg_d[FLAG_OVERFLOW] = 1'b1;
        end else if (e_fin < 10'sd1) begin
            res_d                 = {s2_sign_q, 31'd0};
            flg_d[FLAG_UNDERFLOW] = 1'b1;
        end

        case (s2_sp_q)
            SP_NAN: begin
                res_d               = QNAN;
                flg_d               = 3'b000;
                flg_d[FLAG_INVALID] = s2_inv_q;
            end
            SP_INF: begin
                res_d = {s2_sign_q, 8'hFF, 23'd0};
                flg_d = 3'b000;
            end
            SP_ZERO: begin
                res_d = {s2_sign_q, 31'd0};
                flg_d = 3'b000;
            end
            default: ;
        endcase
    end

    logic [31:0] result_q;
    logic [2:0]  flags_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            result_q <= '0;
            flags_q  <= '0;
        end else if (en_i && v2_i) begin
            result_q <= res_d;
            flags_q  <= flg_d & {3{FLAGS_EN}};
        end
    end

    assign result_o = result_q;
    assign flags_o  = flags_q;
endmodule

// File: rtl/float32_mul_pipe.sv
// rtl/float32_mul_pipe.sv - LANES-wide pipelined float32 multiplier with shared valid/ready handshake
module float32_mul_pipe
    import float32_pkg::*;
#(
    parameter int LANES    = 4,
    parameter bit FLAGS_EN = 1'b1
) (
    input  logic                 in_clk,
    input  logic                 in_rst,
    float32_mul_pipe_if.slave    bus
);
    logic en;
    logic v1_q, v2_q, v3_q;
    logic v1_d, v2_d, v3_d;

    // The whole pipe freezes only when a finished result is not taken
    assign en = !(v3_q && !bus.in_result_ready);

    always_comb begin
        v1_d = v1_q;
        v2_d = v2_q;
        v3_d = v3_q;
        if (en) begin
            v1_d = bus.in_valid;
            v2_d = v1_q;
            v3_d = v2_q;
        end
    end

    always_ff @(posedge in_clk) begin
        if (in_rst) begin
            v1_q <= 1'b0;
            v2_q <= 1'b0;
            v3_q <= 1'b0;
        end else begin
            v1_q <= v1_d;
            v2_q <= v2_d;
            v3_q <= v3_d;
        end
    end

    assign bus.out_ready = en || in_rst;
    assign bus.out_valid = v3_q;

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        float32_mul_lane #(
            .FLAGS_EN (FLAGS_EN)
        ) u_lane (
            .clk_i    (in_clk),
            .rst_i    (in_rst),
            .en_i     (en),
            .v0_i     (bus.in_valid),
            .v1_i     (v1_q),
            .v2_i     (v2_q),
            .a_i      (bus.in_A[32*i +: 32]),
            .b_i      (bus.in_B[32*i +: 32]),
            .result_o (bus.out_result[32*i +: 32]),
            .flags_o  (bus.out_flags[3*i +: 3])
        );
    end
endmodule

// File: tb/tb_float32_mul_pipe.sv
// tb/tb_float32_mul_pipe.sv - randomized self-checking bench for float32_mul_pipe (16-lane and 1-lane)
module tb_float32_mul_pipe;
    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    float32_mul_pipe_if #(.LANES(16)) bus16 ();
    float32_mul_pipe_if #(.LANES(1))  bus1 ();

    assign bus1.in_valid        = bus16.in_valid;
    assign bus1.in_result_ready = bus16.in_result_ready;
    assign bus1.in_A            = bus16.in_A[31:0];
    assign bus1.in_B            = bus16.in_B[31:0];

    float32_mul_pipe #(.LANES(16), .FLAGS_EN(1'b1)) u_dut16 (
        .in_clk (clk),
        .in_rst (rst),
        .bus    (bus16)
    );

    float32_mul_pipe #(.LANES(1), .FLAGS_EN(1'b1)) u_dut1 (
        .in_clk (clk),
        .in_rst (rst),
        .bus    (bus1)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, want);
        end
    endtask

    // Reference: exact integer product, rounding decided from the discarded remainder vs one half
    function automatic logic [34:0] ref_mul(input logic [31:0] a, input logic [31:0] b);
        logic sign;
        int ea, eb, e, sh;
        logic a_nan, b_nan, a_snan, b_snan, a_inf, b_inf, a_zero, b_zero;
        longint unsigned ma, mb, p, q, rem, half;
        sign   = a[31] ^ b[31];
        ea     = int'(a[30:23]);
        eb     = int'(b[30:23]);
        a_nan  = (ea == 255) && (a[22:0] != 0);
        b_nan  = (eb == 255) && (b[22:0] != 0);
        a_snan = a_nan && !a[22];
        b_snan = b_nan && !b[22];
        a_inf  = (ea == 255) && (a[22:0] == 0);
        b_inf  = (eb == 255) && (b[22:0] == 0);
        a_zero = (ea == 0);
        b_zero = (eb == 0);
        if (a_nan || b_nan) return {a_snan || b_snan, 2'b00, 32'h7FC00000};
        if ((a_inf && b_zero) || (a_zero && b_inf)) return {3'b100, 32'h7FC00000};
        if (a_inf || b_inf) return {3'b000, sign, 8'hFF, 23'd0};
        if (a_zero || b_zero) return {3'b000, sign, 31'd0};
        ma = 64'h80_0000 + 64'(a[22:0]);
        mb = 64'h80_0000 + 64'(b[22:0]);
        p  = ma * mb;
        e  = ea + eb - 127;
        sh = 23;
        if (p >= (64'd1 << 47)) begin
            sh = 24;
            e++;
        end
        q    = p >> sh;
        rem  = p - (q << sh);
        half = 64'd1 << (sh - 1);
        if (rem > half || (rem == half && q[0])) q++;
        if (q == (64'd1 << 24)) begin
            q = q >> 1;
            e++;
        end
        if (e >= 255) return {3'b010, sign, 8'hFF, 23'd0};
        if (e < 1)    return {3'b001, sign, 31'd0};
        return {3'b000, sign, e[7:0], q[22:0]};
    endfunction

    function automatic logic [31:0] rand_op();
        int         k = $urandom_range(0, 19);
        logic [7:0] e;
        logic [22:0] f = 23'($urandom);
        logic       s = 1'($urandom);
        case (k)
            0: e = 8'h00;
            1: begin e = 8'hFF; f = '0; end
            2: begin e = 8'hFF; f = f | 23'd1; end
            3: e = 8'($urandom_range(1, 20));
            4: e = 8'($urandom_range(235, 254));
            5: begin e = 8'($urandom_range(120, 134)); f = '1; end
            default: e = 8'($urandom_range(96, 158));
        endcase
        return {s, e, f};
    endfunction

    logic [511:0] exp_res_q[$];
    logic [47:0]  exp_flg_q[$];
    int           acc_cyc_q[$];
    logic         ovr_en = 1'b0;
    logic [31:0]  ovr_res = '0;
    logic [2:0]   ovr_flg = '0;
    logic         lat_check = 1'b0;
    logic         rst_prev = 1'b1;
    int           n_del = 0;

    always @(negedge clk) begin
        logic [511:0] er;
        logic [47:0]  ef;
        logic [34:0]  m;
        int           ac;
        if (rst) begin
            exp_res_q.delete();
            exp_flg_q.delete();
            acc_cyc_q.delete();
            check("rst_out_ready", bus16.out_ready, 1);
        end else begin
            if (rst_prev) check("post_rst_out_valid", bus16.out_valid, 0);
            if (bus16.out_valid && bus16.in_result_ready) begin
                if (exp_res_q.size() == 0) begin
                    check("spurious_out_valid", bus16.out_valid, 0);
                end else begin
                    er = exp_res_q.pop_front();
                    ef = exp_flg_q.pop_front();
                    ac = acc_cyc_q.pop_front();
                    for (int i = 0; i < 16; i++) begin
                        check($sformatf("res_l%0d", i), bus16.out_result[32*i +: 32], er[32*i +: 32]);
                        check($sformatf("flg_l%0d", i), bus16.out_flags[3*i +: 3], ef[3*i +: 3]);
                    end
                    check("one_lane_valid", bus1.out_valid, 1);
                    check("one_lane_res", bus1.out_result, er[31:0]);
                    check("one_lane_flg", bus1.out_flags, ef[2:0]);
                    if (lat_check) check("latency", cyc - ac, 3);
                    n_del++;
                end
            end
            if (bus16.in_valid && bus16.out_ready) begin
                for (int i = 0; i < 16; i++) begin
                    m = ref_mul(bus16.in_A[32*i +: 32], bus16.in_B[32*i +: 32]);
                    if (i == 0 && ovr_en) m = {ovr_flg, ovr_res};
                    er[32*i +: 32] = m[31:0];
                    ef[3*i +: 3]   = m[34:32];
                end
                exp_res_q.push_back(er);
                exp_flg_q.push_back(ef);
                acc_cyc_q.push_back(cyc);
            end
        end
        rst_prev = rst;
    end

    task automatic fill(input logic [31:0] a0, input logic [31:0] b0);
        bus16.in_A[31:0] = a0;
        bus16.in_B[31:0] = b0;
        for (int i = 1; i < 16; i++) begin
            bus16.in_A[32*i +: 32] = rand_op();
            bus16.in_B[32*i +: 32] = rand_op();
        end
    endtask

    task automatic send(input logic [31:0] a0, input logic [31:0] b0, input logic [31:0] r0, input logic [2:0] f0);
        int w = 0;
        @(posedge clk); #1;
        fill(a0, b0);
        ovr_en = 1'b1;
        ovr_res = r0;
        ovr_flg = f0;
        bus16.in_valid = 1'b1;
        @(negedge clk);
        while (!bus16.out_ready && w < 50) begin
            w++;
            @(negedge clk);
        end
        if (w >= 50) check("send_timeout", w, 0);
    endtask

    task automatic go_idle();
        @(posedge clk); #1;
        bus16.in_valid = 1'b0;
        ovr_en = 1'b0;
    endtask

    task automatic drain();
        int w = 0;
        while (exp_res_q.size() != 0 && w < 200) begin
            @(negedge clk);
            w++;
        end
        check("drain_empty", exp_res_q.size(), 0);
    endtask

    localparam int ND = 10;
    logic [31:0] d_a   [ND] = '{32'h40000000, 32'h3F800001, 32'h3F800800, 32'h7F800000, 32'h7F7FFFFF,
                                32'h00800000, 32'hC0000000, 32'h7F800001, 32'h7FC00001, 32'h00000001};
    logic [31:0] d_b   [ND] = '{32'h40400000, 32'h3F800001, 32'h3F800800, 32'h00000000, 32'h40000000,
                                32'h3F000000, 32'h7F800000, 32'h3F800000, 32'h00000000, 32'h7F000000};
    logic [31:0] d_r   [ND] = '{32'h40C00000, 32'h3F800002, 32'h3F801000, 32'h7FC00000, 32'h7F800000,
                                32'h00000000, 32'hFF800000, 32'h7FC00000, 32'h7FC00000, 32'h00000000};
    logic [2:0]  d_f   [ND] = '{3'b000, 3'b000, 3'b000, 3'b100, 3'b010,
                                3'b001, 3'b000, 3'b100, 3'b000, 3'b000};

    logic [511:0] bp_a [10];
    logic [511:0] bp_b [10];
    logic [511:0] hold_vec;
    logic [34:0]  hm;
    int           sent;
    int           del0;
    logic         took;

    initial begin
        rst = 1'b1;
        bus16.in_valid = 1'b0;
        bus16.in_result_ready = 1'b1;
        bus16.in_A = '0;
        bus16.in_B = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("reset_out_valid", bus16.out_valid, 0);
        check("reset_out_result", bus16.out_result == '0, 1);
        check("reset_out_flags", bus16.out_flags == '0, 1);
        check("reset_out_ready", bus16.out_ready, 1);

        lat_check = 1'b1;
        for (int d = 0; d < ND; d++) send(d_a[d], d_b[d], d_r[d], d_f[d]);
        go_idle();
        drain();

        lat_check = 1'b0;
        for (int n = 0; n < 10; n++) begin
            for (int i = 0; i < 16; i++) begin
                bp_a[n][32*i +: 32] = rand_op();
                bp_b[n][32*i +: 32] = rand_op();
            end
        end
        for (int i = 0; i < 16; i++) begin
            hm = ref_mul(bp_a[1][32*i +: 32], bp_b[1][32*i +: 32]);
            hold_vec[32*i +: 32] = hm[31:0];
        end
        sent = 0;
        del0 = n_del;
        for (int c = 0; c < 30; c++) begin
            @(posedge clk); #1;
            bus16.in_result_ready = !(c >= 4 && c <= 7);
            if (sent < 10) begin
                bus16.in_valid = 1'b1;
                bus16.in_A = bp_a[sent];
                bus16.in_B = bp_b[sent];
            end else begin
                bus16.in_valid = 1'b0;
            end
            @(negedge clk);
            if (c >= 4 && c <= 7) begin
                check("bp_out_ready_low", bus16.out_ready, 0);
                check("bp_out_valid_hold", bus16.out_valid, 1);
                check("bp_result_hold", bus16.out_result == hold_vec, 1);
            end
            if (c == 3 || c == 8) check("bp_out_ready_high", bus16.out_ready, 1);
            if (bus16.in_valid && bus16.out_ready) sent++;
        end
        drain();
        check("bp_accepted", sent, 10);
        check("bp_delivered", n_del - del0, 10);

        lat_check = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            fill(rand_op(), rand_op());
            bus16.in_valid = 1'b1;
            if (c == 2) rst = 1'b1;
            @(negedge clk);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        bus16.in_valid = 1'b0;
        repeat (8) @(negedge clk);
        del0 = n_del;
        send(32'h40000000, 32'h40400000, 32'h40C00000, 3'b000);
        go_idle();
        drain();
        check("post_rst_delivered", n_del - del0, 1);

        lat_check = 1'b0;
        took = 1'b0;
        for (int c = 0; c < 600; c++) begin
            @(posedge clk); #1;
            bus16.in_result_ready = ($urandom_range(0, 3) != 0);
            if (!bus16.in_valid || took) begin
                bus16.in_valid = ($urandom_range(0, 3) != 0);
                fill(rand_op(), rand_op());
            end
            @(negedge clk);
            took = bus16.in_valid && bus16.out_ready;
        end
        @(posedge clk); #1;
        bus16.in_valid = 1'b0;
        bus16.in_result_ready = 1'b1;
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/float32_mul_pipe.md
FLOAT32_MUL_PIPE -- requirements
Module: float32_mul_pipe

Interface
REQ-001 Parameter LANES, default 4, is the number of independent float32 multiply lanes, legal range 1..16.
REQ-002 Parameter FLAGS_EN, default 1, enables the out_flags port logic; when 0, out_flags SHALL be tied to zero.
REQ-003 in_clk  input  1  single clock; all logic on its rising edge.
REQ-004 in_rst  input  1  synchronous, active-high reset.
REQ-005 in_valid  input  1  operand beat valid.
REQ-006 out_ready  output  1  block accepts a beat this cycle.
REQ-007 in_A  input  32*LANES  IEEE-754 binary32 operands; lane i at [32i+31:32i].
REQ-008 in_B  input  32*LANES  second operands, same packing.
REQ-009 out_valid  output  1  result beat valid.
REQ-010 in_result_ready  input  1  downstream accepts the result beat.
REQ-011 out_result  output  32*LANES  products, same packing as in_A.
REQ-012 out_flags  output  3*LANES  per lane {invalid, overflow, underflow}; lane i at [3i+2:3i].

Function
REQ-013 A beat SHALL be accepted when in_valid and out_ready are both high; a result SHALL be transferred when out_valid and in_result_ready are both high.
REQ-014 The pipeline SHALL have three stages: S1 unpack/classify, S2 24x24 mantissa product, S3 normalise/round/pack. Latency SHALL be 3 cycles from acceptance to out_valid when there is no stall.
REQ-015 Each stage SHALL carry a valid bit. Global enable = !(S3 valid && !in_result_ready). All stages advance only when enable is high, and out_ready SHALL equal enable.
REQ-016 While stalled, out_result, out_flags and out_valid SHALL hold stable. Bubbles are not compressed.
REQ-017 Throughput SHALL be one beat per cycle while in_result_ready stays high.
REQ-018 Result sign SHALL be signA XOR signB for every class, including zero and infinity.
REQ-019 Exponent arithmetic SHALL use a 10-bit signed intermediate: eA + eB - 127, plus 1 if product bit 47 is set, plus 1 on rounding carry-out.
REQ-020 Rounding SHALL be round-to-nearest-even using guard, round and sticky bits (sticky = OR of all discarded lower product bits).
REQ-021 Subnormal inputs (exp=0) SHALL be treated as zero (flush-to-zero).
REQ-022 A final biased exponent < 1 SHALL yield signed zero with underflow=1.
REQ-023 A final biased exponent >= 255 SHALL yield signed infinity with overflow=1.
REQ-024 Any NaN input, or infinity times zero, SHALL yield 0x7FC00000. Invalid=1 SHALL be set only for infinity times zero and for signalling-NaN inputs (exp=255, mantissa!=0, bit22=0).
REQ-025 Infinity times a nonzero finite value SHALL yield signed infinity with no flags. Zero times a finite value SHALL yield signed zero with no flags.
REQ-026 Special-case classification SHALL be computed in S1 and carried to S3; S3 overrides the arithmetic result when a special case is flagged.
REQ-027 Lanes SHALL be fully independent; one beat shares a single valid bit across all lanes.

Reset
REQ-028 On in_rst, all stage valid bits SHALL be cleared, so out_valid=0 in the next cycle.
REQ-029 On in_rst, out_result and out_flags SHALL be cleared to 0.
REQ-030 While in_rst is high, out_ready SHALL be 1.
REQ-031 Beats in flight at reset SHALL be discarded, never emitted.
REQ-032 Datapath registers other than the outputs need not be reset.

Structure
REQ-033 Package float32_pkg SHALL hold: bias 127, the canonical qNaN 0x7FC00000, exponent width 8, mantissa width 23, the flag bit indices, and an unpacked-float struct typedef {sign, exp, man, is_zero, is_inf, is_nan, is_snan}.
REQ-034 A per-lane sub-module float32_mul_lane (three stages, with stage enable and valid passed in) SHALL be instantiated LANES times. Handshake and valid logic SHALL live in the top level.

Verification
REQ-035 0x40000000 x 0x40400000 -> 0x40C00000, flags 000, out_valid exactly 3 cycles after acceptance.
REQ-036 Rounding checks with flags 000:
- 0x3F800001 x 0x3F800001 -> 0x3F800002.
- Tie case 0x3F800800 x 0x3F800800 -> 0x3F801000 (round to even).
REQ-037 Special and range checks:
- 0x7F800000 x 0x00000000 -> 0x7FC00000, invalid=1.
- 0x7F7FFFFF x 0x40000000 -> 0x7F800000, overflow=1.
- 0x00800000 x 0x3F000000 -> 0x00000000, underflow=1.
- 0xC0000000 x 0x7F800000 -> 0xFF800000, flags 000.
REQ-038 Backpressure: stream 10 beats with in_result_ready low for cycles 4-7. Required: out_ready low while stalled, outputs stable, all 10 results delivered in order with none lost or duplicated.
REQ-039 Reset mid-operation: assert in_rst with 3 beats in flight. Required: out_valid=0 next cycle, none of the 3 beats ever emitted, and the next beat after reset returns a correct result after 3 cycles.
REQ-040 Run with LANES=1 and LANES=16, using different operands per lane. Required: each lane independently matches a bit-exact reference model, with flush-to-zero applied to subnormal inputs.
